// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes and FSM state encoding for mips_seq_alu
package alu_pkg;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider (divider under MULDIV_DIV_EN)
module muldiv_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef MULDIV_DIV_EN
    input  logic             div_mode,
`endif
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             last
);

    // acc is {product_hi, multiplier} for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [SHAMT_W-1:0] count;
    logic               neg_res;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] prod_fix;

    assign mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign prod_fix = neg_res ? -acc : acc;
    assign last     = (count == SHAMT_W'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
    logic             mode_div;
    logic             neg_rem;
    logic             div_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH:0]   trial;

    assign trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};

    always_comb begin
        hi_out = prod_fix[2*WIDTH-1:WIDTH];
        lo_out = prod_fix[WIDTH-1:0];
        if (mode_div) begin
            if (div_zero) begin
                hi_out = a_raw;
                lo_out = '1;
            end else begin
                hi_out = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo_out = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end
`else
    assign hi_out = prod_fix[2*WIDTH-1:WIDTH];
    assign lo_out = prod_fix[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            opnd    <= '0;
            count   <= '0;
            neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            mode_div <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
`endif
        end else if (load) begin
            count   <= '0;
            neg_res <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            mode_div <= div_mode;
            neg_rem  <= sgn & a[WIDTH-1];
            div_zero <= (b == '0);
            a_raw    <= a;
            if (div_mode) begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end
`else
            acc  <= {{WIDTH{1'b0}}, mag_b};
            opnd <= mag_a;
`endif
        end else if (step) begin
            count <= count + 1'b1;
`ifdef MULDIV_DIV_EN
            if (mode_div) begin
                // Restore is implicit: a failed trial just keeps the shifted remainder
                if (!trial[WIDTH])
                    acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc <= {add_sum, acc[WIDTH-1:1]};
            end
`else
            acc <= {add_sum, acc[WIDTH-1:1]};
`endif
        end
    end

endmodule

// File: rtl/mips_seq_alu.sv
// rtl/mips_seq_alu.sv - clocked MIPS R-type ALU with iterative mult/div and HI/LO; div/divu need MULDIV_DIV_EN
module mips_seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out,
    output logic               overflow,
    output logic               zero,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_t           state;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_known;
    logic             is_mul;
    logic             is_div;
    logic             sgn;
    logic             md_load;
    logic             md_last;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

    assign is_mul = (funct == FN_MULT) || (funct == FN_MULTU);
`ifdef MULDIV_DIV_EN
    assign is_div = (funct == FN_DIV) || (funct == FN_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign sgn     = (funct == FN_MULT) || (funct == FN_DIV);
    assign md_load = (state == ST_IDLE) && start && (is_mul || is_div);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_known = 1'b1;
        case (funct)
            FN_SLL:  alu_res = b << shamt;
            FN_SRL:  alu_res = b >> shamt;
            FN_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
            FN_SLLV: alu_res = b << a[SHAMT_W-1:0];
            FN_SRLV: alu_res = b >> a[SHAMT_W-1:0];
            FN_ADD:  begin alu_res = sum_ext[WIDTH-1:0]; alu_carry = sum_ext[WIDTH]; alu_ovf = add_ovf; end
            FN_ADDU: begin alu_res = sum_ext[WIDTH-1:0]; alu_carry = sum_ext[WIDTH]; end
            FN_SUB:  begin alu_res = diff_ext[WIDTH-1:0]; alu_carry = ~diff_ext[WIDTH]; alu_ovf = sub_ovf; end
            FN_SUBU: begin alu_res = diff_ext[WIDTH-1:0]; alu_carry = ~diff_ext[WIDTH]; end
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_XOR:  alu_res = a ^ b;
            FN_NOR:  alu_res = ~(a | b);
            // Sign of the difference is wrong exactly when the subtraction overflowed
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH-1] ^ sub_ovf};
            FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
            FN_MFHI: alu_res = hi;
            FN_MFLO: alu_res = lo;
            default: alu_known = 1'b0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (md_load),
        .step    ((state == ST_MUL) || (state == ST_DIV)),
`ifdef MULDIV_DIV_EN
        .div_mode(is_div),
`endif
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .hi_out  (md_hi),
        .lo_out  (md_lo),
        .last    (md_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                        end else if (is_div) begin
                            state <= ST_DIV;
                            busy  <= 1'b1;
                        end else begin
                            result    <= alu_res;
                            carry_out <= alu_carry;
                            overflow  <= alu_ovf;
                            zero      <= alu_known && (alu_res == '0);
                            done      <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_last)
                        state <= ST_FIN;
                end
                ST_FIN: begin
                    hi    <= md_hi;
                    lo    <= md_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
